dram_responder: RTL and testbench

DRAM_RESPONDER -- requirements
Module: dram_responder

---
 rtl/dram_pkg.sv | 11 +
 rtl/dram_strobe_sync.sv | 65 ++++++
 rtl/dram_responder.sv | 212 +++++++++++++++++++++
 tb/tb_dram_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and widths for the DRAM responder model.
package dram_pkg;
   localparam int DA_W = 9;
   localparam int D_W  = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ROW_OPEN   = 2'd1,
      COL_ACTIVE = 2'd2
   } dram_state_e;
endpackage

// File: rtl/dram_strobe_sync.sv
// Input registers for the DRAM bus plus RAS/CAS edge detectors; edges compare
// the current registered strobe against the previous registered strobe.
module dram_strobe_sync
   import dram_pkg::*;
(
   input  logic            clk_i,
   input  logic            reset,
   input  logic            ras_n_i,
   input  logic            cas_n_i,
   input  logic            we_n_i,
   input  logic [DA_W-1:0] da_i,
   input  logic [D_W-1:0]  d_i,
   output logic            we_n_o,
   output logic [DA_W-1:0] da_o,
   output logic [D_W-1:0]  d_o,
   output logic            ras_fall_o,
   output logic            ras_rise_o,
   output logic            cas_fall_o,
   output logic            cas_rise_o
);
   logic            ras_n_d, ras_n_q, ras_prev_d, ras_prev_q;
   logic            cas_n_d, cas_n_q, cas_prev_d, cas_prev_q;
   logic            we_n_d, we_n_q;
   logic [DA_W-1:0] da_d, da_q;
   logic [D_W-1:0]  d_d, d_q;

   always_comb begin
      ras_n_d    = ras_n_i;
      cas_n_d    = cas_n_i;
      ras_prev_d = ras_n_q;
      cas_prev_d = cas_n_q;
      we_n_d     = we_n_i;
      da_d       = da_i;
      d_d        = d_i;
   end

   // Strobe history resets high so a strobe held low through reset reads as a fresh fall.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         ras_n_q    <= 1'b1;
         cas_n_q    <= 1'b1;
         ras_prev_q <= 1'b1;
         cas_prev_q <= 1'b1;
         we_n_q     <= 1'b1;
         da_q       <= '0;
         d_q        <= '0;
      end else begin
         ras_n_q    <= ras_n_d;
         cas_n_q    <= cas_n_d;
         ras_prev_q <= ras_prev_d;
         cas_prev_q <= cas_prev_d;
         we_n_q     <= we_n_d;
         da_q       <= da_d;
         d_q        <= d_d;
      end
   end

   assign we_n_o     = we_n_q;
   assign da_o       = da_q;
   assign d_o        = d_q;
   assign ras_fall_o = ras_prev_q & ~ras_n_q;
   assign ras_rise_o = ~ras_prev_q & ras_n_q;
   assign cas_fall_o = cas_prev_q & ~cas_n_q;
   assign cas_rise_o = ~cas_prev_q & cas_n_q;
endmodule

// File: rtl/dram_responder.sv
// Asynchronous-DRAM slave model: RAS/CAS decoding, page mode, CAS latency and
// protocol checks. Define DRAM_RESPONDER_REFRESH_CHECK_EN for the refresh-window checker.
module dram_responder
   import dram_pkg::*;
#(
   parameter int ROW_BITS      = 4,
   parameter int COL_BITS      = 4,
   parameter int CAS_LAT       = 1,
   parameter int REFRESH_LIMIT = 1000
) (
   input  logic            clk_i,
   input  logic            reset,
   input  logic            ras_n_i,
   input  logic            cas_n_i,
   input  logic            we_n_i,
   input  logic [DA_W-1:0] da_i,
   input  logic [D_W-1:0]  d_i,
   output logic [D_W-1:0]  q_o,
   output logic            q_oe_o,
   output logic            proto_err_o,
   output logic            refresh_err_o,
   output logic [15:0]     access_cnt_o
);
   localparam int         ADDR_W    = ROW_BITS + COL_BITS;
   localparam int         MEM_DEPTH = 1 << ADDR_W;
   localparam logic [1:0] LAT_INIT  = (CAS_LAT > 0) ? 2'(CAS_LAT - 1) : 2'd0;

   logic            we_n_q, ras_fall, ras_rise, cas_fall, cas_rise;
   logic [DA_W-1:0] da_q;
   logic [D_W-1:0]  d_q;
   logic            unused_da;

   dram_strobe_sync u_sync (
      .clk_i      (clk_i),
      .reset      (reset),
      .ras_n_i    (ras_n_i),
      .cas_n_i    (cas_n_i),
      .we_n_i     (we_n_i),
      .da_i       (da_i),
      .d_i        (d_i),
      .we_n_o     (we_n_q),
      .da_o       (da_q),
      .d_o        (d_q),
      .ras_fall_o (ras_fall),
      .ras_rise_o (ras_rise),
      .cas_fall_o (cas_fall),
      .cas_rise_o (cas_rise)
   );
   assign unused_da = ^da_q;

   dram_state_e         state_d, state_q;
   logic [ROW_BITS-1:0] row_d, row_q;
   logic [COL_BITS-1:0] col_d, col_q, rd_col;
   logic                wr_pend_d, wr_pend_q, rd_pend_d, rd_pend_q;
   logic [D_W-1:0]      wr_data_d, wr_data_q, q_d, q_q, rd_data;
   logic [1:0]          lat_cnt_d, lat_cnt_q;
   logic                q_oe_d, q_oe_q, proto_err_d, proto_err_q, mem_we;
   logic [15:0]         access_cnt_d, access_cnt_q;
   logic [D_W-1:0]      mem_q [MEM_DEPTH];

   // With zero latency data is fetched on the detection edge, before col_q is loaded.
   assign rd_col  = (CAS_LAT == 0) ? da_q[COL_BITS-1:0] : col_q;
   assign rd_data = mem_q[{row_q, rd_col}];

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      wr_pend_d    = 1'b0;
      wr_data_d    = wr_data_q;
      rd_pend_d    = rd_pend_q;
      lat_cnt_d    = lat_cnt_q;
      q_d          = q_q;
      q_oe_d       = q_oe_q;
      proto_err_d  = proto_err_q;
      access_cnt_d = access_cnt_q;
      mem_we       = wr_pend_q;
      case (state_q)
         IDLE: begin
            if (cas_fall) proto_err_d = 1'b1;
            if (ras_fall) begin
               row_d   = da_q[ROW_BITS-1:0];
               state_d = ROW_OPEN;
            end
         end
         ROW_OPEN: begin
            if (ras_rise) begin
               state_d = IDLE;
            end else if (cas_fall) begin
               col_d        = da_q[COL_BITS-1:0];
               access_cnt_d = access_cnt_q + 16'd1;
               state_d      = COL_ACTIVE;
               if (!we_n_q) begin
                  wr_pend_d = 1'b1;
                  wr_data_d = d_q;
               end else if (CAS_LAT == 0) begin
                  q_d    = rd_data;
                  q_oe_d = 1'b1;
               end else begin
                  rd_pend_d = 1'b1;
                  lat_cnt_d = LAT_INIT;
               end
            end
         end
         COL_ACTIVE: begin
            // A write is committed one clock after entry, so an abort here still blocks it.
            if (ras_rise) begin
               state_d     = IDLE;
               proto_err_d = 1'b1;
               mem_we      = 1'b0;
               q_oe_d      = 1'b0;
               rd_pend_d   = 1'b0;
            end else if (cas_rise) begin
               state_d = ROW_OPEN;
               q_oe_d  = 1'b0;
               if (rd_pend_q) begin
                  proto_err_d = 1'b1;
                  rd_pend_d   = 1'b0;
               end
            end else if (rd_pend_q) begin
               if (lat_cnt_q == 2'd0) begin
                  q_d       = rd_data;
                  q_oe_d    = 1'b1;
                  rd_pend_d = 1'b0;
               end else begin
                  lat_cnt_d = lat_cnt_q - 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q      <= IDLE;
         row_q        <= '0;
         col_q        <= '0;
         wr_pend_q    <= 1'b0;
         wr_data_q    <= '0;
         rd_pend_q    <= 1'b0;
         lat_cnt_q    <= '0;
         q_q          <= '0;
         q_oe_q       <= 1'b0;
         proto_err_q  <= 1'b0;
         access_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         wr_pend_q    <= wr_pend_d;
         wr_data_q    <= wr_data_d;
         rd_pend_q    <= rd_pend_d;
         lat_cnt_q    <= lat_cnt_d;
         q_q          <= q_d;
         q_oe_q       <= q_oe_d;
         proto_err_q  <= proto_err_d;
         access_cnt_q <= access_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we && !reset) mem_q[{row_q, col_q}] <= wr_data_q;
   end

   assign q_o          = q_q;
   assign q_oe_o       = q_oe_q;
   assign proto_err_o  = proto_err_q;
   assign access_cnt_o = access_cnt_q;

`ifdef DRAM_RESPONDER_REFRESH_CHECK_EN
   localparam int WIN_W = $clog2(REFRESH_LIMIT + 1);
   localparam int ROWS  = 1 << ROW_BITS;

   logic [ROWS-1:0]  bitmap_d, bitmap_q, mark;
   logic [WIN_W-1:0] win_cnt_d, win_cnt_q;
   logic             refresh_err_d, refresh_err_q;

   // A row refreshed on a window-restart edge is carried into the new window.
   always_comb begin
      mark = '0;
      if (state_q == ROW_OPEN && ras_rise) mark[row_q] = 1'b1;
      bitmap_d      = bitmap_q | mark;
      win_cnt_d     = win_cnt_q + WIN_W'(1);
      refresh_err_d = refresh_err_q;
      if (&bitmap_q) begin
         bitmap_d  = mark;
         win_cnt_d = '0;
      end else if (win_cnt_q == WIN_W'(REFRESH_LIMIT)) begin
         refresh_err_d = 1'b1;
         bitmap_d      = mark;
         win_cnt_d     = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         bitmap_q      <= '0;
         win_cnt_q     <= '0;
         refresh_err_q <= 1'b0;
      end else begin
         bitmap_q      <= bitmap_d;
         win_cnt_q     <= win_cnt_d;
         refresh_err_q <= refresh_err_d;
      end
   end

   assign refresh_err_o = refresh_err_q;
`else
   assign refresh_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_dram_responder.sv
// Randomized bench for dram_responder: transaction-level memory model with
// read-window timing derived from the CAS latency rules, plus directed protocol cases.
module tb_dram_responder;
   import dram_pkg::*;

   localparam int CAS_LAT       = 1;
   localparam int REFRESH_LIMIT = 100;
`ifdef DRAM_RESPONDER_REFRESH_CHECK_EN
   localparam logic EXP_REF_ERR = 1'b1;
`else
   localparam logic EXP_REF_ERR = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            reset;
   logic            ras_n_i, cas_n_i, we_n_i;
   logic [DA_W-1:0] da_i;
   logic [D_W-1:0]  d_i;
   logic [D_W-1:0]  q_o;
   logic            q_oe_o, proto_err_o, refresh_err_o;
   logic [15:0]     access_cnt_o;

   always #5 clk_i = ~clk_i;

   dram_responder #(
      .ROW_BITS      (4),
      .COL_BITS      (4),
      .CAS_LAT       (CAS_LAT),
      .REFRESH_LIMIT (REFRESH_LIMIT)
   ) dut (
      .clk_i         (clk_i),
      .reset         (reset),
      .ras_n_i       (ras_n_i),
      .cas_n_i       (cas_n_i),
      .we_n_i        (we_n_i),
      .da_i          (da_i),
      .d_i           (d_i),
      .q_o           (q_o),
      .q_oe_o        (q_oe_o),
      .proto_err_o   (proto_err_o),
      .refresh_err_o (refresh_err_o),
      .access_cnt_o  (access_cnt_o)
   );

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [7:0]  ref_mem [256];
   logic [7:0]  exp_q [$];
   logic [7:0]  exp_qo;
   logic [15:0] exp_cnt;
   logic        exp_perr;
   logic [3:0]  cur_row;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      ras_n_i = 1'b1;
      cas_n_i = 1'b1;
      we_n_i  = 1'b1;
      step();
      step();
      reset    = 1'b0;
      cyc      = 0;
      exp_cnt  = '0;
      exp_perr = 1'b0;
      exp_qo   = '0;
      exp_q.delete();
   endtask

   task automatic ras_open(input logic [3:0] row);
      cur_row = row;
      da_i    = {5'($urandom_range(0, 31)), row};
      ras_n_i = 1'b0;
      step();
      repeat ($urandom_range(0, 1)) step();
   endtask

   task automatic ras_close();
      ras_n_i = 1'b1;
      step();
      step();
      check_eq("access_cnt", access_cnt_o, exp_cnt);
      check_eq("proto_err", proto_err_o, exp_perr);
   endtask

   // One CAS pulse of len low samples; the read window is edges k+1+CAS_LAT .. k+len.
   task automatic cas_access(input logic [3:0] col, input logic wr, input logic [7:0] data,
                             input int len);
      logic [7:0] addr;
      addr    = {cur_row, col};
      da_i    = {5'($urandom_range(0, 31)), col};
      we_n_i  = ~wr;
      d_i     = data;
      cas_n_i = 1'b0;
      if (!wr) exp_q.push_back(ref_mem[addr]);
      for (int j = 1; j <= len + 2; j++) begin
         if (j == len + 1) cas_n_i = 1'b1;
         step();
         if (!wr && j == 2 + CAS_LAT && j <= len + 1) exp_qo = exp_q.pop_front();
         check_eq("q_oe", q_oe_o, (!wr && j >= 2 + CAS_LAT && j <= len + 1));
         check_eq("q_o", q_o, exp_qo);
      end
      if (!wr && len + 1 < 2 + CAS_LAT) begin
         exp_perr = 1'b1;
         void'(exp_q.pop_front());
      end
      if (wr) ref_mem[addr] = data;
      exp_cnt++;
      we_n_i = 1'b1;
   endtask

   initial begin
      da_i = '0;
      d_i  = '0;
      do_reset();
      check_eq("rst_q", q_o, 8'h00);
      check_eq("rst_q_oe", q_oe_o, 1'b0);
      check_eq("rst_proto", proto_err_o, 1'b0);
      check_eq("rst_refresh", refresh_err_o, 1'b0);
      check_eq("rst_cnt", access_cnt_o, 16'd0);

      // Page-mode write then latency-checked reads of the same row.
      ras_open(4'd3);
      cas_access(4'd1, 1'b1, 8'hA5, 2);
      cas_access(4'd2, 1'b1, 8'h5A, 2);
      ras_close();
      check_eq("pm_cnt", access_cnt_o, 16'd2);
      check_eq("pm_proto", proto_err_o, 1'b0);
      ras_open(4'd3);
      cas_access(4'd2, 1'b0, 8'h00, 4);
      check_eq("rd_5a", q_o, 8'h5A);
      cas_access(4'd1, 1'b0, 8'h00, 3);
      check_eq("rd_a5", q_o, 8'hA5);
      ras_close();

      // Fill the whole array so every later read has a known value.
      for (int r = 0; r < 16; r++) begin
         ras_open(4'(r));
         for (int c = 0; c < 16; c++) cas_access(4'(c), 1'b1, 8'($urandom), 2);
         ras_close();
      end

      for (int s = 0; s < 40; s++) begin
         ras_open(4'($urandom_range(0, 15)));
         repeat ($urandom_range(1, 4)) begin
            logic wr;
            wr = 1'($urandom_range(0, 1));
            cas_access(4'($urandom_range(0, 15)), wr, 8'($urandom),
                       wr ? int'($urandom_range(1, 4)) : int'($urandom_range(2, 4)));
         end
         ras_close();
      end

      // CAS-before-RAS is flagged and ignored; a normal access afterwards still works.
      do_reset();
      cas_n_i = 1'b0;
      step(); step(); step();
      cas_n_i = 1'b1;
      step(); step();
      exp_perr = 1'b1;
      check_eq("cbr_proto", proto_err_o, 1'b1);
      check_eq("cbr_cnt", access_cnt_o, 16'd0);
      ras_open(4'd5);
      cas_access(4'd7, 1'b1, 8'($urandom), 2);
      cas_access(4'd7, 1'b0, 8'h00, 3);
      ras_close();

      // CAS rising before the data is ready.
      do_reset();
      ras_open(4'd2);
      cas_access(4'($urandom_range(0, 15)), 1'b0, 8'h00, 1);
      ras_close();
      check_eq("short_proto", proto_err_o, 1'b1);

      // RAS rising during a write aborts it.
      do_reset();
      ras_open(4'd4);
      cas_access(4'd4, 1'b1, 8'h11, 2);
      ras_close();
      ras_open(4'd4);
      da_i    = {5'd0, 4'd4};
      we_n_i  = 1'b0;
      d_i     = 8'hEE;
      cas_n_i = 1'b0;
      step();
      ras_n_i = 1'b1;
      step();
      step();
      check_eq("abort_q_oe", q_oe_o, 1'b0);
      cas_n_i = 1'b1;
      we_n_i  = 1'b1;
      step(); step();
      exp_cnt++;
      exp_perr = 1'b1;
      check_eq("abort_proto", proto_err_o, 1'b1);
      ras_open(4'd4);
      cas_access(4'd4, 1'b0, 8'h00, 3);
      check_eq("abort_mem44", q_o, 8'h11);
      ras_close();

      // RAS and CAS falling together: row taken, CAS dropped.
      do_reset();
      cur_row = 4'd6;
      da_i    = {5'd3, 4'd6};
      ras_n_i = 1'b0;
      cas_n_i = 1'b0;
      step(); step(); step();
      cas_n_i = 1'b1;
      step(); step();
      exp_perr = 1'b1;
      check_eq("both_cnt", access_cnt_o, 16'd0);
      check_eq("both_proto", proto_err_o, 1'b1);
      cas_access(4'd9, 1'b1, 8'($urandom), 2);
      cas_access(4'd9, 1'b0, 8'h00, 2);
      ras_close();

      // Reset landing on the write-commit edge leaves memory untouched.
      ras_open(4'd8);
      da_i    = {5'd0, 4'd8};
      we_n_i  = 1'b0;
      d_i     = ~ref_mem[8'h88];
      cas_n_i = 1'b0;
      step();
      step();
      do_reset();
      check_eq("mid_rst_q_oe", q_oe_o, 1'b0);
      check_eq("mid_rst_cnt", access_cnt_o, 16'd0);
      check_eq("mid_rst_q", q_o, 8'h00);
      ras_open(4'd8);
      cas_access(4'd8, 1'b0, 8'h00, 2);
      ras_close();

      // Refresh window: 15 of 16 rows, then all 16.
      do_reset();
      for (int r = 0; r < 15; r++) begin
         ras_open(4'(r));
         ras_close();
      end
      while (cyc < 95) step();
      check_eq("ref_partial_early", refresh_err_o, 1'b0);
      while (cyc < 105) step();
      check_eq("ref_partial_late", refresh_err_o, EXP_REF_ERR);
      do_reset();
      for (int r = 0; r < 16; r++) begin
         ras_open(4'(r));
         ras_close();
      end
      while (cyc < 140) step();
      check_eq("ref_full", refresh_err_o, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
